// File: rtl/sad_result_sequencer.sv
// Result capture and display page sequencer for the SAD search core.
// Latches each new best match and rotates XY / SAD / count pages.
module sad_result_sequencer #(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ResultValid,
  input  logic [31:0] XIn,
  input  logic [31:0] YIn,
  input  logic [31:0] SadIn,
  input  logic        Freeze,
  output logic        Ack,
  output logic [15:0] DispLeft,
  output logic [15:0] DispRight,
  output logic [1:0]  Page
);

  localparam int unsigned DW =
    (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XY   = 2'd1,
    S_SAD  = 2'd2,
    S_CNT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [31:0] sad_q, sad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        valid_q;
  logic        ack_q;

  logic        capture;
  logic        expire;
  logic [CNT_W+15:0] cnt_ext;
  logic        unused;

  assign capture = ResultValid & ~valid_q;
  assign expire  = (state_q != S_IDLE) && (dwell_q == LAST) && !Freeze;
  assign cnt_ext = {16'd0, cnt_q};

  // Only the low halves of x/y are ever displayed.
  assign unused = ^{XIn[31:16], YIn[31:16], cnt_ext[CNT_W+15:16]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      capture: state_d = S_XY;
      expire: begin
        case (state_q)
          S_XY:    state_d = S_SAD;
          S_SAD:   state_d = S_CNT;
          S_CNT:   state_d = S_XY;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    DispLeft  = 16'd0;
    DispRight = 16'd0;
    unique case (state_q)
      S_XY: begin
        DispLeft  = x_q;
        DispRight = y_q;
      end
      S_SAD: begin
        DispLeft  = sad_q[31:16];
        DispRight = sad_q[15:0];
      end
      S_CNT: begin
        DispLeft  = 16'd0;
        DispRight = cnt_ext[15:0];
      end
      default: begin
        DispLeft  = 16'd0;
        DispRight = 16'd0;
      end
    endcase
  end

  assign Page = state_q;
  assign Ack  = ack_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    sad_d   = sad_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    if (capture) begin
      x_d   = XIn[15:0];
      y_d   = YIn[15:0];
      sad_d = SadIn;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
    priority case (1'b1)
      capture:            dwell_d = '0;
      state_q == S_IDLE:  dwell_d = '0;
      Freeze:             dwell_d = dwell_q;
      expire:             dwell_d = '0;
      default:            dwell_d = dwell_q + DW'(1);
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dwell_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sad_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sad_q   <= sad_d;
      cnt_q   <= cnt_d;
      valid_q <= ResultValid;
      ack_q   <= capture;
    end
  end

endmodule

// File: tb/tb_sad_result_sequencer.sv
// Directed bench for sad_result_sequencer with a 4-cycle dwell.
// Outputs are packed as {Ack, Page, DispLeft, DispRight} per check.
module tb_sad_result_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ResultValid;
  logic [31:0] XIn;
  logic [31:0] YIn;
  logic [31:0] SadIn;
  logic        Freeze;
  logic        Ack;
  logic [15:0] DispLeft;
  logic [15:0] DispRight;
  logic [1:0]  Page;

  int checks = 0;
  int errors = 0;

  sad_result_sequencer #(
    .DWELL_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ResultValid(ResultValid),
    .XIn(XIn),
    .YIn(YIn),
    .SadIn(SadIn),
    .Freeze(Freeze),
    .Ack(Ack),
    .DispLeft(DispLeft),
    .DispRight(DispRight),
    .Page(Page)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic logic [63:0] pk(input logic a,
                                     input logic [1:0] p,
                                     input logic [15:0] l,
                                     input logic [15:0] r);
    return {29'd0, a, p, l, r};
  endfunction

  logic [63:0] obs;
  assign obs = pk(Ack, Page, DispLeft, DispRight);

  initial begin
    Reset       = 1'b1;
    ResultValid = 1'b0;
    XIn         = '0;
    YIn         = '0;
    SadIn       = '0;
    Freeze      = 1'b0;

    // 1: reset then idle
    tick(3);
    chk("reset", obs, pk(0, 0, 0, 0));
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", obs, pk(0, 0, 0, 0));
    end

    // 2: first capture and full page rotation
    XIn = 32'd3;
    YIn = 32'd7;
    SadIn = 32'h0001_2345;
    ResultValid = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i <= 4)
        chk("rot_xy", obs, pk(i == 1, 1, 16'h0003, 16'h0007));
      else if (i <= 8)
        chk("rot_sad", obs, pk(0, 2, 16'h0001, 16'h2345));
      else if (i <= 12)
        chk("rot_cnt", obs, pk(0, 3, 16'h0000, 16'h0001));
      else
        chk("rot_wrap", obs, pk(0, 1, 16'h0003, 16'h0007));
      if (i == 10) ResultValid = 1'b0;
    end

    // 3: second capture during SAD page, x truncated
    tick(4);
    chk("sad_pg", obs, pk(0, 2, 16'h0001, 16'h2345));
    tick();
    XIn = 32'h0001_0010;
    YIn = 32'd5;
    SadIn = 32'hABCD_0001;
    ResultValid = 1'b1;
    tick();
    chk("cap2", obs, pk(1, 1, 16'h0010, 16'h0005));
    ResultValid = 1'b0;
    tick(4);
    chk("cap2_sad", obs, pk(0, 2, 16'hABCD, 16'h0001));
    tick(4);
    chk("cap2_cnt", obs, pk(0, 3, 16'h0000, 16'h0002));

    // 4: freeze during SAD page
    tick(4);
    chk("pre_frz", obs, pk(0, 1, 16'h0010, 16'h0005));
    tick(4);
    chk("frz_sad", obs, pk(0, 2, 16'hABCD, 16'h0001));
    tick(2);
    Freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_hold", {62'd0, Page}, 64'd2);
    end
    Freeze = 1'b0;
    tick();
    chk("frz_rem1", {62'd0, Page}, 64'd2);
    tick();
    chk("frz_rem2", obs, pk(0, 3, 16'h0000, 16'h0002));

    // 5: capture on the expiry cycle of CNT, with Freeze high
    tick(3);
    chk("exp_cyc", {62'd0, Page}, 64'd3);
    XIn = 32'h0000_1234;
    YIn = 32'h0000_5678;
    SadIn = 32'h0000_00FF;
    ResultValid = 1'b1;
    Freeze = 1'b1;
    tick();
    chk("exp_cap", obs, pk(1, 1, 16'h1234, 16'h5678));
    ResultValid = 1'b0;
    Freeze = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("exp_xy", obs, pk(0, 1, 16'h1234, 16'h5678));
    end
    tick();
    chk("exp_sad", obs, pk(0, 2, 16'h0000, 16'h00FF));

    // 6: reset during SAD page with valid high
    XIn = 32'd9;
    YIn = 32'd8;
    SadIn = 32'h0000_0042;
    ResultValid = 1'b1;
    Reset = 1'b1;
    tick();
    chk("rst_mid", obs, pk(0, 0, 0, 0));
    Reset = 1'b0;
    tick();
    chk("rst_cap", obs, pk(1, 1, 16'h0009, 16'h0008));
    tick();
    chk("rst_noack", obs, pk(0, 1, 16'h0009, 16'h0008));
    tick(7);
    chk("rst_cnt", obs, pk(0, 3, 16'h0000, 16'h0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
